// File: rtl/arbitro_round_robin.sv
// Round-robin arbiter sharing a registered 4:1 bit-select between four requesters.
// Optional ARB_GAP_EN inserts a one-cycle GAP state after every grant end.
module arbitro_round_robin #(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CNT_W     = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_req,
  input  logic [3:0] i_data,
  output logic [3:0] o_gnt,
  output logic [1:0] o_selector,
  output logic       o_q,
  output logic       o_valid,
  output logic       o_busy
);

`ifdef ARB_GAP_EN
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, GRANT} state_t;
`endif

  state_t           state, state_n;
  logic [1:0]       last_gnt, last_gnt_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       gnt_n;
  logic [1:0]       sel_n;
  logic             q_n, valid_n, busy_n;
  logic [1:0]       base, winner;
  logic             found, burst_end, go_grant, go_idle;

  // During GRANT the holder is the search base, so it is lowest priority on re-arbitration.
  assign base      = (state == GRANT) ? o_selector : last_gnt;
  assign burst_end = (cnt == '0) || !i_req[o_selector];

  always_comb begin
    found  = 1'b0;
    winner = base;
    for (int unsigned k = 1; k <= 4; k++) begin
      if (!found && i_req[base + k[1:0]]) begin
        found  = 1'b1;
        winner = base + k[1:0];
      end
    end
  end

  always_comb begin
    state_n    = state;
    last_gnt_n = last_gnt;
    cnt_n      = cnt;
    gnt_n      = o_gnt;
    sel_n      = o_selector;
    q_n        = o_q;
    valid_n    = 1'b0;
    busy_n     = o_busy;
    go_grant   = 1'b0;
    go_idle    = 1'b0;

    case (state)
      IDLE: go_grant = found;
      GRANT: begin
        q_n     = i_data[o_selector];
        // Sample of an early-release cycle is discarded.
        valid_n = i_req[o_selector];
        if (burst_end) begin
          last_gnt_n = o_selector;
`ifdef ARB_GAP_EN
          state_n = GAP;
          gnt_n   = '0;
          busy_n  = 1'b1;
`else
          go_grant = found;
          go_idle  = !found;
`endif
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
`ifdef ARB_GAP_EN
      GAP: begin
        go_grant = found;
        go_idle  = !found;
      end
`endif
      default: go_idle = 1'b1;
    endcase

    if (go_grant) begin
      state_n = GRANT;
      gnt_n   = 4'b0001 << winner;
      sel_n   = winner;
      cnt_n   = CNT_W'(BURST_LEN - 1);
      busy_n  = 1'b1;
    end else if (go_idle) begin
      state_n = IDLE;
      gnt_n   = '0;
      busy_n  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      last_gnt   <= 2'd3;
      cnt        <= '0;
      o_gnt      <= '0;
      o_selector <= '0;
      o_q        <= 1'b0;
      o_valid    <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      state      <= state_n;
      last_gnt   <= last_gnt_n;
      cnt        <= cnt_n;
      o_gnt      <= gnt_n;
      o_selector <= sel_n;
      o_q        <= q_n;
      o_valid    <= valid_n;
      o_busy     <= busy_n;
    end
  end

endmodule

// File: tb/tb_arbitro_round_robin.sv
// Bench for arbitro_round_robin: fixed vector tables, directed sequences, random traffic vs a reference model.
// Honours ARB_GAP_EN the same way the design does.
module tb_arbitro_round_robin;
  localparam int BL = 4;

  logic       clk = 1'b0;
  logic       i_rst, o_q, o_valid, o_busy;
  logic [3:0] i_req, i_data, o_gnt;
  logic [1:0] o_selector;

  int checks = 0;
  int errors = 0;

  arbitro_round_robin #(.BURST_LEN(BL), .CNT_W(4)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_data(i_data),
    .o_gnt(o_gnt), .o_selector(o_selector), .o_q(o_q),
    .o_valid(o_valid), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] data;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       q;
    logic       valid;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [3:0] rq, logic [3:0] d, logic [3:0] g,
                              logic [1:0] s, logic q, logic v, logic b);
    vec_t x;
    x.rst = r; x.req = rq; x.data = d; x.gnt = g; x.sel = s; x.q = q; x.valid = v; x.busy = b;
    return x;
  endfunction

  // Reference model: phase 0 idle, 1 granting, 2 turnaround gap.
  int         ph, holder, left, last;
  logic [3:0] e_gnt;
  logic [1:0] e_sel;
  logic       e_q, e_valid, e_busy;

  function automatic int pick(logic [3:0] r, int from);
    for (int k = 1; k <= 4; k++)
      if (r[(from + k) % 4]) return (from + k) % 4;
    return -1;
  endfunction

  task automatic m_start_or_idle(logic [3:0] r);
    int w;
    w = pick(r, last);
    if (w >= 0) begin
      ph = 1; holder = w; left = BL;
      e_gnt = 4'b0001 << w; e_sel = 2'(w); e_busy = 1'b1;
    end else begin
      ph = 0; e_gnt = 4'b0000; e_busy = 1'b0;
    end
  endtask

  task automatic model_step(logic r, logic [3:0] rq, logic [3:0] d);
    if (r) begin
      ph = 0; holder = 0; left = 0; last = 3;
      e_gnt = '0; e_sel = '0; e_q = 1'b0; e_valid = 1'b0; e_busy = 1'b0;
      return;
    end
    case (ph)
      0: begin
        e_valid = 1'b0;
        m_start_or_idle(rq);
      end
      1: begin
        e_q     = d[holder];
        e_valid = rq[holder];
        if (left == 1 || !rq[holder]) begin
          last = holder;
`ifdef ARB_GAP_EN
          ph = 2; e_gnt = 4'b0000;
`else
          m_start_or_idle(rq);
`endif
        end else begin
          left--;
        end
      end
      default: begin
        e_valid = 1'b0;
        m_start_or_idle(rq);
      end
    endcase
  endtask

  task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic tick(logic r, logic [3:0] rq, logic [3:0] d);
    i_rst = r; i_req = rq; i_data = d;
    @(posedge clk);
    model_step(r, rq, d);
    #1;
  endtask

  task automatic check_model();
    chk("gnt", o_gnt, e_gnt);
    chk("sel", 4'(o_selector), 4'(e_sel));
    chk("valid", 4'(o_valid), 4'(e_valid));
    chk("busy", 4'(o_busy), 4'(e_busy));
    if (e_valid) chk("q", 4'(o_q), 4'(e_q));
  endtask

  initial begin
    logic [3:0] rq;
    logic [3:0] d;

`ifndef ARB_GAP_EN
    tbl.push_back(mk(1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0));
    // early release of requester 0 in its 2nd grant cycle
    tbl.push_back(mk(0, 4'b0011, 4'b0010, 4'b0001, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'b0011, 4'b0010, 4'b0001, 0, 0, 1, 1));
    tbl.push_back(mk(0, 4'b0010, 4'b0010, 4'b0010, 1, 0, 0, 1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 4'b0010, 4'b0010, 4'b0010, 1, 1, 1, 1));
    tbl.push_back(mk(0, 4'b0000, 4'b0010, 4'b0000, 1, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0010, 4'b0000, 1, 0, 0, 0));
    // reset during the 3rd cycle of a burst
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0100, 2, 0, 0, 1));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0100, 2, 0, 1, 1));
    tbl.push_back(mk(1, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0001, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0001, 0, 0, 1, 1));
`else
    tbl.push_back(mk(1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0011, 4'b0010, 4'b0001, 0, 0, 0, 1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 4'b0011, 4'b0010, 4'b0001, 0, 0, 1, 1));
    tbl.push_back(mk(0, 4'b0011, 4'b0010, 4'b0000, 0, 0, 1, 1));
    tbl.push_back(mk(0, 4'b0011, 4'b0010, 4'b0010, 1, 0, 0, 1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 4'b0011, 4'b0010, 4'b0010, 1, 1, 1, 1));
    tbl.push_back(mk(0, 4'b0011, 4'b0010, 4'b0000, 1, 1, 1, 1));
    tbl.push_back(mk(0, 4'b0011, 4'b0010, 4'b0001, 0, 0, 0, 1));
`endif

    i_rst = 1'b1; i_req = '0; i_data = '0;
    #1;
    foreach (tbl[n]) begin
      tick(tbl[n].rst, tbl[n].req, tbl[n].data);
      chk($sformatf("tbl%0d_gnt", n), o_gnt, tbl[n].gnt);
      chk($sformatf("tbl%0d_sel", n), 4'(o_selector), 4'(tbl[n].sel));
      chk($sformatf("tbl%0d_valid", n), 4'(o_valid), 4'(tbl[n].valid));
      chk($sformatf("tbl%0d_busy", n), 4'(o_busy), 4'(tbl[n].busy));
      if (tbl[n].valid || tbl[n].rst) chk($sformatf("tbl%0d_q", n), 4'(o_q), 4'(tbl[n].q));
    end

    // all requesting, data 1010: full rotation plus wrap
    tick(1, 4'h0, 4'h0); check_model();
    for (int i = 0; i < 20; i++) begin tick(0, 4'b1111, 4'b1010); check_model(); end

    // sole requester 2 with toggling data
    tick(1, 4'h0, 4'h0); check_model();
    for (int i = 0; i < 14; i++) begin
      tick(0, 4'b0100, (i % 2 == 0) ? 4'b0100 : 4'b0000);
      check_model();
    end

    // random traffic with sticky requests and rare resets
    tick(1, 4'h0, 4'h0); check_model();
    rq = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
      d = 4'($urandom);
      tick($urandom_range(0, 299) == 0, rq, d);
      check_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
